// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared definitions for the Tetris datapath and the LED board scanner.
//   BOARD_ROWS / BOARD_COLS / BOARD_BITS : geometry of the packed board image
//   scan_state_e                         : board scanner state encoding
// -----------------------------------------------------------------------------
package tetris_pkg;

    localparam int BOARD_ROWS = 8;
    localparam int BOARD_COLS = 4;
    localparam int BOARD_BITS = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ROW_ON = 2'd2,
        BLANK  = 2'd3
    } scan_state_e;

endpackage : tetris_pkg

// File: rtl/scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Per-state tick counter for the board scanner. Restarts from zero whenever
// clear is high and saturates on its terminal count so it never wraps.
// Ports:
//   clka      in  clock
//   restart_n in  asynchronous active-low reset
//   clear     in  reload count to 0 (state entry)
//   limit     in  number of ticks the current state lasts (>= 1)
//   done      out high while count == limit-1 (last cycle of the state)
// -----------------------------------------------------------------------------
module scan_timer #(
    parameter int CW = 1
) (
    input  logic          clka,
    input  logic          restart_n,
    input  logic          clear,
    input  logic [CW:0]   limit,
    output logic          done
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // limit is one bit wider than the count so a limit of 2**CW fits
    assign done = ({1'b0, count_q} == (limit - {{CW{1'b0}}, 1'b1}));

    // next count: clear, hold on terminal count, else increment
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (done) begin
            count_d = count_q;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // count register
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : scan_timer

// File: rtl/board_scan.sv
// -----------------------------------------------------------------------------
// board_scan
// Multiplexed LED scanner for the 8x4 Tetris board. Captures a board image
// once per frame, lights one row at a time for ROW_TICKS cycles with a dark
// BLANK_TICKS gap between rows, and pulses frame_done after row 7's gap.
// All outputs are registered decodes of the scan state, so they trail the
// internal state by one cycle.
// Ports:
//   clka       in  clock
//   restart_n  in  asynchronous active-low reset
//   board_in   in  32-bit board image, row r = bits [4r+3:4r]
//   enable     in  scanning permitted (sampled in IDLE and at frame end)
//   game_over  in  blink request (only with BOARD_SCAN_BLINK_EN)
//   board_ack  out one-cycle pulse when board_in is captured
//   row_sel    out one-hot row drive
//   col_data   out column drive for the lit row
//   frame_done out one-cycle pulse at the end of a frame
// Optional feature: define BOARD_SCAN_BLINK_EN to blank the columns every
// other group of 8 frames while game_over is high.
// -----------------------------------------------------------------------------
module board_scan
    import tetris_pkg::*;
#(
    parameter int ROW_TICKS   = 16,
    parameter int BLANK_TICKS = 2
) (
    input  logic                  clka,
    input  logic                  restart_n,
    input  logic [BOARD_BITS-1:0] board_in,
    input  logic                  enable,
    input  logic                  game_over,
    output logic                  board_ack,
    output logic [BOARD_ROWS-1:0] row_sel,
    output logic [BOARD_COLS-1:0] col_data,
    output logic                  frame_done
);

    localparam int MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
    localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    scan_state_e           state_q, state_d;
    logic [2:0]            row_q, row_d;
    logic [BOARD_BITS-1:0] shadow_q, shadow_d;

    logic                  timer_clear_s;
    logic [CW:0]           timer_limit_s;
    logic                  timer_done_s;
    logic                  frame_end_s;
    logic                  blank_cols_s;

    logic                  board_ack_q, board_ack_d;
    logic                  frame_done_q, frame_done_d;
    logic [BOARD_ROWS-1:0] row_sel_q, row_sel_d;
    logic [BOARD_COLS-1:0] col_data_q, col_data_d;

    // Restart the tick count on every state change; IDLE keeps it parked at 0
    assign timer_clear_s = (state_d != state_q) || (state_q == IDLE);
    assign timer_limit_s = (state_q == BLANK) ? (CW+1)'(BLANK_TICKS) : (CW+1)'(ROW_TICKS);
    assign frame_end_s   = (state_q == BLANK) && (row_q == 3'd7) && timer_done_s;

    scan_timer #(.CW(CW)) u_timer (
        .clka      (clka),
        .restart_n (restart_n),
        .clear     (timer_clear_s),
        .limit     (timer_limit_s),
        .done      (timer_done_s)
    );

`ifdef BOARD_SCAN_BLINK_EN
    logic [3:0] frame_cnt_q;

    // frame counter, advances once per completed frame
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            frame_cnt_q <= 4'd0;
        end else if (frame_end_s) begin
            frame_cnt_q <= frame_cnt_q + 4'd1;
        end else begin
            frame_cnt_q <= frame_cnt_q;
        end
    end

    assign blank_cols_s = game_over && frame_cnt_q[3];
`else
    logic unused_game_over_s;
    assign unused_game_over_s = game_over;
    assign blank_cols_s       = 1'b0;
`endif

    // state register
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q  <= IDLE;
            row_q    <= 3'd0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            shadow_q <= shadow_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                shadow_d = board_in;
                row_d    = 3'd0;
                state_d  = ROW_ON;
            end
            ROW_ON: begin
                if (timer_done_s) begin
                    state_d = BLANK;
                end else begin
                    state_d = ROW_ON;
                end
            end
            BLANK: begin
                if (!timer_done_s) begin
                    state_d = BLANK;
                end else if (row_q == 3'd7) begin
                    state_d = enable ? LOAD : IDLE;
                end else begin
                    row_d   = row_q + 3'd1;
                    state_d = ROW_ON;
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = 3'd0;
            end
        endcase
    end

    // output decode: rows only light in ROW_ON, everything else is dark
    always_comb begin
        board_ack_d  = (state_q == LOAD);
        frame_done_d = frame_end_s;
        row_sel_d    = '0;
        col_data_d   = '0;
        if (state_q == ROW_ON) begin
            row_sel_d = {{(BOARD_ROWS-1){1'b0}}, 1'b1} << row_q;
            if (blank_cols_s) begin
                col_data_d = '0;
            end else begin
                col_data_d = shadow_q[{row_q, 2'b00} +: BOARD_COLS];
            end
        end else begin
            row_sel_d  = '0;
            col_data_d = '0;
        end
    end

    // output registers
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            board_ack_q  <= 1'b0;
            frame_done_q <= 1'b0;
            row_sel_q    <= '0;
            col_data_q   <= '0;
        end else begin
            board_ack_q  <= board_ack_d;
            frame_done_q <= frame_done_d;
            row_sel_q    <= row_sel_d;
            col_data_q   <= col_data_d;
        end
    end

    assign board_ack  = board_ack_q;
    assign frame_done = frame_done_q;
    assign row_sel    = row_sel_q;
    assign col_data   = col_data_q;

endmodule : board_scan

// File: tb/tb_board_scan.sv
// -----------------------------------------------------------------------------
// tb_board_scan
// Self-checking bench for board_scan with ROW_TICKS=2, BLANK_TICKS=1.
// The reference model tracks only an abstract frame position (-1 = idle,
// 0 = capture slot, 1..8P = row/gap slots) plus the captured image; the
// visible outputs after each edge are decoded from the position before it.
// -----------------------------------------------------------------------------
module tb_board_scan;
    import tetris_pkg::*;

    localparam int RT = 2;
    localparam int BT = 1;
    localparam int P  = RT + BT;
    localparam int FL = 8 * P;

    logic                  clka;
    logic                  restart_n;
    logic [BOARD_BITS-1:0] board_in;
    logic                  enable;
    logic                  game_over;
    logic                  board_ack;
    logic [BOARD_ROWS-1:0] row_sel;
    logic [BOARD_COLS-1:0] col_data;
    logic                  frame_done;

    board_scan #(.ROW_TICKS(RT), .BLANK_TICKS(BT)) dut (
        .clka       (clka),
        .restart_n  (restart_n),
        .board_in   (board_in),
        .enable     (enable),
        .game_over  (game_over),
        .board_ack  (board_ack),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_done (frame_done)
    );

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    int vectors     = 0;
    int miscompares = 0;
    int pos         = -1;
    logic [31:0] shadow_m = '0;
    int fc_m        = 0;
    int cyc         = 0;
    int last_edge   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pos      = -1;
        shadow_m = '0;
        fc_m     = 0;
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_row_sel"},    32'(row_sel),    32'd0);
        check({tag, "_col_data"},   32'(col_data),   32'd0);
        check({tag, "_board_ack"},  32'(board_ack),  32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // one clock: predict from the abstract position, advance it, then compare
    task automatic step();
        logic       e_ack, e_fd, lit;
        logic [7:0] e_rs;
        logic [3:0] e_col;
        int         k, row;
        @(posedge clka);
        e_ack = (pos == 0);
        e_fd  = (pos == FL);
        e_rs  = 8'd0;
        e_col = 4'd0;
        if (pos >= 1 && pos <= FL) begin
            k   = pos - 1;
            row = k / P;
            lit = (k % P) < RT;
            if (lit) begin
                e_rs  = 8'd1 << row;
                e_col = shadow_m[row*4 +: 4];
`ifdef BOARD_SCAN_BLINK_EN
                if (game_over && fc_m >= 8) e_col = 4'd0;
`endif
            end
        end
        if (pos == 0) shadow_m = board_in;
        if (pos == FL) fc_m = (fc_m + 1) % 16;
        if (pos == -1 || pos == FL) pos = enable ? 0 : -1;
        else pos = pos + 1;
        last_edge = cyc;
        cyc++;
        #1;
        check("row_sel",    32'(row_sel),    32'(e_rs));
        check("col_data",   32'(col_data),   32'(e_col));
        check("board_ack",  32'(board_ack),  32'(e_ack));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("onehot", 32'($countones(row_sel) <= 1), 32'd1);
        check("ack_fd_excl", 32'(board_ack && frame_done), 32'd0);
    endtask

    initial begin
        int first_ack, first_fd, second_ack, found;
        restart_n = 1'b0;
        board_in  = 32'h8421_F00F;
        enable    = 1'b1;
        game_over = 1'b0;
        model_reset();
        #12;
        check_dark("reset");
        @(negedge clka);
        restart_n = 1'b1;
        cyc       = 0;

        // first frames from reset release; image swapped during row 3 of frame 2
        first_ack  = -1;
        first_fd   = -1;
        second_ack = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (board_ack && first_ack < 0) first_ack = last_edge;
            else if (board_ack && second_ack < 0) second_ack = last_edge;
            if (frame_done && first_fd < 0) first_fd = last_edge;
            if (last_edge == 36) board_in = 32'h0;
        end
        check("first_ack_cycle",  32'(first_ack),  32'd1);
        check("first_fd_cycle",   32'(first_fd),   32'd25);
        check("second_ack_cycle", 32'(second_ack), 32'd26);

        // drop enable during row 5, let the frame finish, then re-arm
        board_in = 32'h5A5A_3C3C;
        for (int i = 0; i < 40; i++) begin
            step();
            if (last_edge == 67) enable = 1'b0;
        end
        check_dark("idle");
        enable = 1'b1;
        step();
        step();
        check("rearm_ack", 32'(board_ack), 32'd1);

        // randomized image, enable and game_over
        for (int i = 0; i < 300; i++) begin
            board_in  = $urandom;
            enable    = ($urandom_range(0, 9) != 0);
            game_over = $urandom_range(0, 1) == 1;
            step();
        end

        // asynchronous reset while a row is lit
        enable = 1'b1;
        found  = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            step();
            if (row_sel != 8'd0) found = 1;
        end
        check("found_row_on", 32'(found), 32'd1);
        #2;
        restart_n = 1'b0;
        enable    = 1'b0;
        #1;
        check_dark("async_reset");
        model_reset();
        repeat (2) @(posedge clka);
        #1;
        check_dark("in_reset");
        @(negedge clka);
        restart_n = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // blink scenario: full image, game_over held for 17 frames
        board_in  = 32'hFFFF_FFFF;
        game_over = 1'b1;
        enable    = 1'b1;
        for (int i = 0; i < 17 * (FL + 1) + 2; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_board_scan

// File: doc/board_scan.md
BOARD_SCAN -- requirements
Module: board_scan

Interface
REQ-001 SHALL have parameter ROW_TICKS, default 16, clka cycles each row is lit (minimum 1).
REQ-002 SHALL have parameter BLANK_TICKS, default 2, dark clka cycles between rows (minimum 1).
REQ-003 SHALL have port clka  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port restart_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port board_in  input  32  board image from the datapath's board_out; row r = bits [4r+3:4r], row 0 = top, bit 4r = leftmost column.
REQ-006 SHALL have port enable  input  1  scanning permitted.
REQ-007 SHALL have port game_over  input  1  game-over indication (used only under REQ-024).
REQ-008 SHALL have port board_ack  output  1  one-cycle pulse when board_in is captured.
REQ-009 SHALL have port row_sel  output  8  one-hot active-high row drive.
REQ-010 SHALL have port col_data  output  4  active-high column drive for the selected row.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse after row 7's blank interval ends.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, ROW_ON, BLANK, plus a 3-bit row index and a tick counter.
- IDLE: enable=1 -> LOAD next cycle; else stay.
- LOAD: lasts exactly one cycle.
  - Shadow register <= board_in.
  - board_ack=1.
  - Row index <= 0.
  - Next state -> ROW_ON.
- ROW_ON: lasts exactly ROW_TICKS cycles, then -> BLANK.
- BLANK: lasts exactly BLANK_TICKS cycles, then:
  - row<7: row+1, -> ROW_ON.
  - row=7: frame_done=1 on BLANK's last cycle, then -> LOAD if enable=1, else -> IDLE.
REQ-013 SHALL drive, in ROW_ON, row_sel = 1<<row and col_data = shadow[4*row+3:4*row].
REQ-014 SHALL drive row_sel=0 and col_data=0 in IDLE, LOAD and BLANK (break-before-make, no ghosting).
REQ-015 SHALL sample board_in only in LOAD; board_in changes mid-frame SHALL NOT affect the current frame (no tearing).
REQ-016 SHALL sample enable only at IDLE and at the frame boundary; deasserting mid-frame completes the current frame.
REQ-017 SHALL take exactly 1 + 8*(ROW_TICKS+BLANK_TICKS) cycles per frame, LOAD to LOAD with enable held 1.
REQ-018 SHALL give first-row latency after IDLE sees enable=1 of: LOAD on the next cycle, row 0 lit on the cycle after.
REQ-019 SHALL size the tick counter as $clog2(max(ROW_TICKS,BLANK_TICKS)) bits (minimum 1), reload it to 0 on every state entry, and never let it wrap within a state.
REQ-020 SHALL keep board_ack and frame_done mutually exclusive, each exactly one cycle wide.

Reset
REQ-021 SHALL, while restart_n=0, asynchronously force:
- state=IDLE, row index=0, tick counter=0, shadow=0;
- board_ack=0, frame_done=0, row_sel=0, col_data=0.
REQ-022 SHALL, on reset mid-frame, go dark immediately; after release, resume per REQ-012 from IDLE with no partial frame.
REQ-023 SHALL register all outputs; no output SHALL depend combinationally on inputs.

Configuration
REQ-024 SHALL, with macro BOARD_SCAN_BLINK_EN defined:
- keep a 4-bit frame counter, +1 on each frame_done, wrapping 15->0, reset to 0;
- while game_over=1 and frame_counter[3]=1, force col_data=0 in ROW_ON (row_sel still cycles).
REQ-025 SHALL, with BOARD_SCAN_BLINK_EN undefined, ignore game_over and omit the frame counter; all other timing is identical.

Structure
REQ-026 SHALL take the following from shared package tetris_pkg (shared with the datapath):
- BOARD_ROWS=8, BOARD_COLS=4, BOARD_BITS=32;
- the scan state enum (IDLE, LOAD, ROW_ON, BLANK).
REQ-027 SHALL place the tick counter in sub-module scan_timer, with ports:
- inputs: clka, restart_n, clear, limit;
- output: done.
- done is high on the cycle count==limit-1.

Verification
REQ-028 With ROW_TICKS=2 and BLANK_TICKS=1, board_in=32'h8421_F00F, enable=1 from reset release:
- board_ack on cycle 1;
- row 0 on cycles 2-3 with col_data=4'hF; row 1 cols 4'h0;
- frame_done on cycle 25; next board_ack on cycle 26.
REQ-029 Change board_in to 32'h0 during row 3 -> rows 4-7 still show the old image; the next frame shows all zeros.
REQ-030 Drop enable during row 5 -> rows 5-7 complete, frame_done pulses, then IDLE with outputs 0; re-raise enable -> board_ack on the next cycle.
REQ-031 Assert restart_n=0 mid-ROW_ON -> row_sel and col_data are 0 within the same cycle, asynchronously; after release the outputs remain 0 while enable=0.
REQ-032 Check the BLANK states: for every cycle between rows, row_sel=0 and col_data=0, and row_sel is never non-one-hot.
REQ-033 BOARD_SCAN_BLINK_EN defined, game_over=1, board_in=32'hFFFF_FFFF:
- frames 0-7 show col_data=4'hF;
- frames 8-15 show col_data=4'h0 while rows still scan.
- With the macro undefined, all frames show 4'hF.
